// File: rtl/axis_sw_sched_pkg.sv
// Shared definitions for the AXIS switch upstream scheduler: defaults,
// source indices and the scheduler state encoding.
package axis_sw_sched_pkg;

   localparam int PORTS_DEF = 3;
   localparam int CNT_W_DEF = 4;
   localparam int TID_W     = $clog2(PORTS_DEF);

   localparam logic [PORTS_DEF-1:0] HI_MASK_DEF      = 3'b101;
   localparam logic [PORTS_DEF-1:0] LAST_SUPPORT_DEF = 3'b000;

   typedef logic [TID_W-1:0] tid_t;

   // Source indices: user project, axilite-axis, logic analyzer
   localparam tid_t TID_UP = 2'd0;
   localparam tid_t TID_AA = 2'd1;
   localparam tid_t TID_LA = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_HI   = 2'd2
   } state_e;

endpackage

// File: rtl/axis_sw_sched_if.sv
// Request/grant bundle between the switch sources and the scheduler.
interface axis_sw_sched_if
   import axis_sw_sched_pkg::*;
#(
   parameter int PORTS = PORTS_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   localparam int ID_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [PORTS-1:0] req;
   logic [PORTS-1:0] hi_req;
   logic             beat;
   logic             last;
   logic [CNT_W-1:0] cfg_burst;
   logic [CNT_W-1:0] cfg_starve;
   logic [PORTS-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             grant_hi;
   logic             starve_evt;

   modport slave (
      input  req, hi_req, beat, last, cfg_burst, cfg_starve,
      output grant, grant_id, grant_hi, starve_evt
   );

   modport master (
      output req, hi_req, beat, last, cfg_burst, cfg_starve,
      input  grant, grant_id, grant_hi, starve_evt
   );
endinterface

// File: rtl/axis_sw_rr_pick.sv
// Combinational round-robin picker: first set bit of i_vec at or above
// i_ptr, wrapping to index 0.
module axis_sw_rr_pick #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] i_vec,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_onehot,
   output logic [W-1:0] o_idx,
   output logic         o_found
);

   // Scan N positions starting from the pointer
   always_comb begin
      int         w_pos;
      logic [W-1:0] w_sel;
      o_onehot = '0;
      o_idx    = '0;
      o_found  = 1'b0;
      w_pos    = 0;
      w_sel    = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= N) begin
            w_pos = w_pos - N;
         end else begin
            w_pos = w_pos;
         end
         w_sel = W'(w_pos);
         if (!o_found && i_vec[w_sel]) begin
            o_found         = 1'b1;
            o_idx           = w_sel;
            o_onehot[w_sel] = 1'b1;
         end else begin
            o_found = o_found;
         end
      end
   end

endmodule

// File: rtl/axis_sw_sched.sv
// Upstream scheduler for the AXIS switch: two-level round-robin grant of
// the single output stream with burst limit and starvation guard.
module axis_sw_sched
   import axis_sw_sched_pkg::*;
#(
   parameter int               PORTS        = PORTS_DEF,
   parameter logic [PORTS-1:0] HI_MASK      = HI_MASK_DEF,
   parameter logic [PORTS-1:0] LAST_SUPPORT = LAST_SUPPORT_DEF,
   parameter int               CNT_W        = CNT_W_DEF
) (
   input  logic           axis_clk,
   input  logic           axi_reset_n,
   axis_sw_sched_if.slave io_sw
);
   localparam int              ID_W    = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(PORTS - 1);

   state_e           r_state, w_state_nxt;
   logic [PORTS-1:0] r_grant, w_grant_nxt;
   logic [ID_W-1:0]  r_grant_id, w_id_nxt;
   logic             r_grant_hi, w_hi_nxt;
   logic             r_starve_evt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_burst_lim, w_lim_nxt;
   logic [CNT_W-1:0] r_starve_cnt, w_scnt_nxt, w_scnt_inc;
   logic [ID_W-1:0]  r_ptr_hi, w_ptr_hi_nxt;
   logic [ID_W-1:0]  r_ptr_n, w_ptr_n_nxt;

   logic [PORTS-1:0] w_hcand, w_ncand, w_hi_oh, w_n_oh;
   logic [ID_W-1:0]  w_hi_idx, w_n_idx;
   logic             w_hi_found, w_n_found;
   logic             w_nwait, w_rel, w_starve_rel, w_arb;

   assign w_hcand    = io_sw.req & io_sw.hi_req & HI_MASK;
   assign w_ncand    = io_sw.req;
   assign w_nwait    = |(w_ncand & ~r_grant);
   assign w_scnt_inc = r_starve_cnt + CNT_W'(1);

   axis_sw_rr_pick #(.N(PORTS), .W(ID_W)) u_pick_hi (
      .i_vec(w_hcand), .i_ptr(r_ptr_hi),
      .o_onehot(w_hi_oh), .o_idx(w_hi_idx), .o_found(w_hi_found)
   );

   axis_sw_rr_pick #(.N(PORTS), .W(ID_W)) u_pick_n (
      .i_vec(w_ncand), .i_ptr(r_ptr_n),
      .o_onehot(w_n_oh), .o_idx(w_n_idx), .o_found(w_n_found)
   );

   // Release detection, counters and same-cycle re-arbitration
   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_id_nxt     = r_grant_id;
      w_hi_nxt     = r_grant_hi;
      w_cnt_nxt    = r_cnt;
      w_lim_nxt    = r_burst_lim;
      w_scnt_nxt   = r_starve_cnt;
      w_ptr_hi_nxt = r_ptr_hi;
      w_ptr_n_nxt  = r_ptr_n;
      w_rel        = 1'b0;
      w_starve_rel = 1'b0;
      w_arb        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_rel = 1'b0;
         end
         ST_NORM: begin
            if (io_sw.beat && (io_sw.last || (r_cnt == r_burst_lim))) begin
               w_rel = 1'b1;
            end else if (io_sw.beat) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
               w_cnt_nxt = r_cnt;
            end
         end
         ST_HI: begin
            if (io_sw.beat && w_nwait) begin
               w_scnt_nxt   = w_scnt_inc;
               w_starve_rel = (io_sw.cfg_starve != '0) && (w_scnt_inc == io_sw.cfg_starve);
            end else begin
               w_scnt_nxt = r_starve_cnt;
            end
            // A beat on the cycle hi_req drops still completes at this edge
            w_rel = !io_sw.hi_req[r_grant_id]
                  || (io_sw.beat && io_sw.last && LAST_SUPPORT[r_grant_id])
                  || w_starve_rel;
         end
         default: begin
            w_rel = 1'b1;
         end
      endcase

      w_arb = (r_state == ST_IDLE) || w_rel;

      // A starvation release blocks the high level for this one arbitration
      if (w_arb) begin
         if (w_hi_found && !w_starve_rel) begin
            w_state_nxt  = ST_HI;
            w_grant_nxt  = w_hi_oh;
            w_id_nxt     = w_hi_idx;
            w_hi_nxt     = 1'b1;
            w_scnt_nxt   = '0;
            w_ptr_hi_nxt = (w_hi_idx == LAST_ID) ? '0 : w_hi_idx + ID_W'(1);
         end else if (w_n_found) begin
            w_state_nxt = ST_NORM;
            w_grant_nxt = w_n_oh;
            w_id_nxt    = w_n_idx;
            w_hi_nxt    = 1'b0;
            w_cnt_nxt   = '0;
            w_lim_nxt   = io_sw.cfg_burst;
            w_ptr_n_nxt = (w_n_idx == LAST_ID) ? '0 : w_n_idx + ID_W'(1);
         end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_id_nxt    = '0;
            w_hi_nxt    = 1'b0;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // State and grant registers
   always_ff @(posedge axis_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_grant_id   <= '0;
         r_grant_hi   <= 1'b0;
         r_starve_evt <= 1'b0;
         r_cnt        <= '0;
         r_burst_lim  <= '0;
         r_starve_cnt <= '0;
         r_ptr_hi     <= '0;
         r_ptr_n      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_grant_id   <= w_id_nxt;
         r_grant_hi   <= w_hi_nxt;
         r_starve_evt <= w_starve_rel;
         r_cnt        <= w_cnt_nxt;
         r_burst_lim  <= w_lim_nxt;
         r_starve_cnt <= w_scnt_nxt;
         r_ptr_hi     <= w_ptr_hi_nxt;
         r_ptr_n      <= w_ptr_n_nxt;
      end
   end

   assign io_sw.grant      = r_grant;
   assign io_sw.grant_id   = r_grant_id;
   assign io_sw.grant_hi   = r_grant_hi;
   assign io_sw.starve_evt = r_starve_evt;

endmodule

// File: tb/tb_axis_sw_sched.sv
// Directed and randomized bench for axis_sw_sched against a cycle-level
// reference model of the grant rules.
module tb_axis_sw_sched;
   import axis_sw_sched_pkg::*;

   localparam logic [2:0] HM = 3'b101;
   localparam logic [2:0] LS = 3'b100;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   // Reference model state: granted port (-1 idle), level, counters, pointers
   int m_g, m_cnt, m_lim, m_scnt, m_phi, m_pn;
   bit m_hi, m_sev;

   axis_sw_sched_if #(.PORTS(3), .CNT_W(4)) sif ();

   axis_sw_sched #(
      .PORTS(3), .HI_MASK(HM), .LAST_SUPPORT(LS), .CNT_W(4)
   ) dut (
      .axis_clk(clk),
      .axi_reset_n(rst_n),
      .io_sw(sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_g = -1; m_hi = 1'b0; m_cnt = 0; m_lim = 0; m_scnt = 0;
      m_phi = 0; m_pn = 0; m_sev = 1'b0;
   endtask

   // Next-state of the model from the inputs present before the edge
   task automatic model_step();
      bit rel, srel, waiting;
      int pick, p;
      rel = 1'b0; srel = 1'b0; waiting = 1'b0; pick = -1;
      if (m_g >= 0 && !m_hi) begin
         if (sif.beat) begin
            if (sif.last || m_cnt == m_lim) rel = 1'b1;
            else m_cnt = m_cnt + 1;
         end
      end else if (m_g >= 0) begin
         for (int q = 0; q < 3; q++) if (sif.req[q] && q != m_g) waiting = 1'b1;
         if (sif.beat && waiting) begin
            m_scnt = (m_scnt + 1) % 16;
            if (sif.cfg_starve != 4'd0 && m_scnt == int'(sif.cfg_starve)) srel = 1'b1;
         end
         if (!sif.hi_req[m_g] || (sif.beat && sif.last && LS[m_g]) || srel) rel = 1'b1;
      end
      m_sev = srel;
      if (m_g < 0 || rel) begin
         if (!srel) begin
            for (int k = 0; k < 3; k++) begin
               p = (m_phi + k) % 3;
               if (pick < 0 && sif.req[p] && sif.hi_req[p] && HM[p]) pick = p;
            end
         end
         if (pick >= 0) begin
            m_g = pick; m_hi = 1'b1; m_scnt = 0; m_phi = (pick + 1) % 3;
         end else begin
            for (int k = 0; k < 3; k++) begin
               p = (m_pn + k) % 3;
               if (pick < 0 && sif.req[p]) pick = p;
            end
            if (pick >= 0) begin
               m_g = pick; m_hi = 1'b0; m_cnt = 0; m_lim = int'(sif.cfg_burst);
               m_pn = (pick + 1) % 3;
            end else begin
               m_g = -1; m_hi = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [2:0] eg;
      logic [1:0] eid;
      eg  = (m_g < 0) ? 3'b000 : (3'b001 << m_g);
      eid = (m_g < 0) ? 2'd0 : 2'(m_g);
      chk("grant", 32'(sif.grant), 32'(eg));
      chk("grant_id", 32'(sif.grant_id), 32'(eid));
      chk("grant_hi", 32'(sif.grant_hi), 32'(m_hi));
      chk("starve_evt", 32'(sif.starve_evt), 32'(m_sev));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(logic [2:0] rq, logic [2:0] hr, logic bt, logic ls);
      sif.req = rq; sif.hi_req = hr; sif.beat = bt; sif.last = ls;
   endtask

   task automatic do_reset();
      drive(3'b000, 3'b000, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int nb, nidle, npulse;
      n_vec = 0; n_err = 0;
      rst_n = 1'b1;
      drive(3'b000, 3'b000, 1'b0, 1'b0);
      sif.cfg_burst = 4'd0; sif.cfg_starve = 4'd0;
      #2;
      do_reset();

      // Round-robin of normal bursts, 4 beats each, no bubbles
      sif.cfg_burst = 4'd3;
      drive(3'b111, 3'b000, 1'b1, 1'b0);
      tick();
      chk("rr_first", 32'(sif.grant), 32'(3'b001 << TID_UP));
      nidle = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (sif.grant == 3'b000) nidle++;
         if (i == 4)  chk("rr_second", 32'(sif.grant), 32'(3'b001 << TID_AA));
         if (i == 8)  chk("rr_third", 32'(sif.grant), 32'(3'b001 << TID_LA));
         if (i == 12) chk("rr_wrap", 32'(sif.grant), 32'(3'b001 << TID_UP));
      end
      chk("rr_no_bubble", 32'(nidle), 32'd0);

      // Normal burst on port 1 is not preempted by a high request
      do_reset();
      sif.cfg_burst = 4'd7; sif.cfg_starve = 4'd0;
      drive(3'b010, 3'b000, 1'b1, 1'b0);
      tick();
      nb = 0;
      for (int i = 0; i < 11; i++) begin
         if (sif.grant == 3'b010 && sif.beat) nb++;
         tick();
         if (i == 0) drive(3'b110, 3'b100, 1'b1, 1'b0);
      end
      chk("nopreempt_beats", 32'(nb), 32'd8);
      chk("nopreempt_grant", 32'(sif.grant), 32'(3'b100));
      chk("nopreempt_hi", 32'(sif.grant_hi), 32'd1);

      // High grant on port 0 survives tlast, released when hi_req drops
      do_reset();
      drive(3'b001, 3'b001, 1'b1, 1'b0);
      tick();
      tick();
      sif.last = 1'b1;
      tick();
      sif.last = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("hi_held", 32'(sif.grant), 32'(3'b001));
      drive(3'b000, 3'b000, 1'b0, 1'b0);
      tick();
      chk("hi_released", 32'(sif.grant), 32'(3'b000));

      // Starvation guard on port 2 high grant
      do_reset();
      sif.cfg_burst = 4'd1; sif.cfg_starve = 4'd4;
      drive(3'b110, 3'b100, 1'b1, 1'b0);
      npulse = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (sif.starve_evt) npulse++;
         if (i == 4) begin
            chk("starve_grant", 32'(sif.grant), 32'(3'b010));
            chk("starve_norm", 32'(sif.grant_hi), 32'd0);
         end
      end
      chk("starve_pulses", 32'(npulse), 32'd1);
      chk("starve_back_hi", 32'(sif.grant), 32'(3'b100));

      // Granted source drops valid without a beat: grant is held
      do_reset();
      sif.cfg_burst = 4'd15; sif.cfg_starve = 4'd0;
      drive(3'b001, 3'b000, 1'b0, 1'b0);
      tick();
      sif.req = 3'b000;
      for (int i = 0; i < 3; i++) tick();
      chk("drop_held", 32'(sif.grant), 32'(3'b001));
      drive(3'b011, 3'b000, 1'b1, 1'b1);
      tick();
      chk("drop_last_rel", 32'(sif.grant), 32'(3'b010));

      // Reset mid-burst clears grant at once and resets pointers
      do_reset();
      sif.cfg_burst = 4'd7;
      drive(3'b010, 3'b000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_grant", 32'(sif.grant), 32'd0);
      chk("rst_hi", 32'(sif.grant_hi), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(3'b110, 3'b000, 1'b0, 1'b0);
      tick();
      chk("rst_first_grant", 32'(sif.grant), 32'(3'b010));

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) sif.req = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) sif.hi_req = 3'($urandom_range(0, 7));
         sif.beat = ($urandom_range(0, 3) != 0);
         sif.last = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 31) == 0) sif.cfg_burst = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) sif.cfg_starve = 4'($urandom_range(0, 6));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
